// File: rtl/sa_ram_rd_stream_61x65.sv
// rtl/sa_ram_rd_stream_61x65.sv - streams a word range out of a 61x65 registered-read RAM
// Optional macro SA_RAM_RD_LEN_CHECK_EN rejects out-of-range commands with a cmd_err pulse.
module sa_ram_rd_stream_61x65 #(
    parameter int OUT_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_addr,
    input  logic [5:0]  cmd_len,
    output logic [5:0]  ram_ra,
    output logic        ram_re,
    output logic        ram_ore,
    input  logic [64:0] ram_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        cmd_err
);

    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C   = (CW+1)'(OUT_DEPTH);
    localparam logic [5:0]  LAST_ADDR = 6'd60;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [5:0]      r_ra;
    logic [5:0]      r_remain;
    logic            r_re_d1;
    logic            r_re_d2;
    logic            r_last_d1;
    logic            r_last_d2;
    logic [65:0]     r_mem [OUT_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_accept;
    logic            w_bad;
    logic            w_issue;
    logic            w_last_issue;
    logic            w_push;
    logic            w_pop;
    logic [CW:0]     w_occupancy;
    logic [65:0]     w_head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef SA_RAM_RD_LEN_CHECK_EN
    logic r_err;
    assign w_bad = (cmd_addr > LAST_ADDR) || (cmd_len > LAST_ADDR);
    always_ff @(posedge clk) begin
        if (reset) r_err <= 1'b0;
        else       r_err <= w_accept && w_bad;
    end
    assign cmd_err = r_err;
`else
    assign w_bad   = 1'b0;
    assign cmd_err = 1'b0;
`endif

    // Buffered words plus reads still travelling through the RAM pipeline
    assign w_occupancy  = {1'b0, r_count} + (CW+1)'(r_re_d1) + (CW+1)'(r_re_d2);
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_issue      = (r_state == ISSUE) && (w_occupancy < DEPTH_C);
    assign w_last_issue = w_issue && (r_remain == 6'd0);
    assign w_push       = r_re_d2;
    assign w_pop        = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        ram_re      = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (w_accept && !w_bad) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                ram_re = w_issue;
                if (w_last_issue) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_pop && out_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ra      <= 6'd0;
            r_remain  <= 6'd0;
            r_re_d1   <= 1'b0;
            r_re_d2   <= 1'b0;
            r_last_d1 <= 1'b0;
            r_last_d2 <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_accept) begin
                r_ra     <= cmd_addr;
                r_remain <= cmd_len;
            end else if (w_issue) begin
                r_ra     <= (r_ra == LAST_ADDR) ? 6'd0 : r_ra + 6'd1;
                r_remain <= r_remain - 6'd1;
            end
            r_re_d1   <= w_issue;
            r_re_d2   <= r_re_d1;
            r_last_d1 <= w_last_issue;
            r_last_d2 <= r_last_d1;
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Data storage needs no reset: reads are gated by r_count
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_last_d2, ram_dout};
    end

    always_comb begin
        w_head    = r_mem[r_rd_ptr];
        out_valid = (r_count != '0);
        out_data  = out_valid ? w_head[64:0] : 65'd0;
        out_last  = out_valid & w_head[65];
    end

    assign ram_ra  = r_ra;
    assign ram_ore = r_re_d1;

endmodule

// File: tb/tb_sa_ram_rd_stream_61x65.sv
// tb/tb_sa_ram_rd_stream_61x65.sv - self-checking bench for sa_ram_rd_stream_61x65
module tb_sa_ram_rd_stream_61x65;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_addr;
    logic [5:0]  cmd_len;
    logic [5:0]  ram_ra;
    logic        ram_re;
    logic        ram_ore;
    logic [64:0] ram_dout = '0;
    logic        out_valid;
    logic        out_ready;
    logic [64:0] out_data;
    logic        out_last;
    logic        busy;
    logic        cmd_err;

    logic [64:0] mem [61];
    logic [64:0] ram_lat = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sa_ram_rd_stream_61x65 #(.OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore), .ram_dout(ram_dout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .cmd_err(cmd_err)
    );

    // Two-stage registered-read RAM: address latch on ram_re, output register on ram_ore
    always @(posedge clk) begin
        if (ram_re)  ram_lat  <= (ram_ra <= 6'd60) ? mem[ram_ra] : 'x;
        if (ram_ore) ram_dout <= ram_lat;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input int addr, input int len, input int rdy_pct, input bit noisy);
        logic [65:0] exp_q[$];
        logic [65:0] exp_w;
        logic [65:0] prev_word;
        int cyc, issued, first_pop, last_pop, bufd, h1, h2, pop, budget;
        bit stall, fin;
        for (int k = 0; k <= len; k++) exp_q.push_back({(k == len), mem[(addr + k) % 61]});
        @(negedge clk);
        check("cmd_ready_idle", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_addr  = addr[5:0];
        cmd_len   = len[5:0];
        out_ready = 1'b0;
        @(negedge clk);
        cmd_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_addr  = 6'($urandom_range(0, 63));
        cmd_len   = 6'($urandom_range(0, 63));
        cyc = 1; issued = 0; first_pop = -1; last_pop = -1;
        bufd = 0; h1 = 0; h2 = 0; stall = 1'b0; fin = 1'b0; prev_word = '0;
        budget = 200 + (len + 1) * 40;
        while (!fin && cyc < budget) begin
            check("ram_ore_delay", int'(ram_ore), h1);
            check("cmd_ready_busy", int'(cmd_ready), 0);
            check("busy_high", int'(busy), 1);
            check("cmd_err_quiet", int'(cmd_err), 0);
            if (cyc < 4) check("early_valid", int'(out_valid), 0);
            if (cyc == 1) check("first_re", int'(ram_re), 1);
            if (ram_re) begin
                check("re_gate", int'(bufd + h1 + h2 < DEPTH), 1);
                check("ram_ra", int'(ram_ra), (addr + issued) % 61);
                issued++;
                check("re_count", int'(issued <= len + 1), 1);
            end
            check("no_overflow", int'(bufd <= DEPTH), 1);
            if (stall) begin
                check("hold_valid", int'(out_valid), 1);
                check_w("hold_word", {out_last, out_data}, prev_word);
            end
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            pop = int'(out_valid && out_ready);
            if (pop != 0) begin
                check("word_avail", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    check_w("word", {out_last, out_data}, exp_w);
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                    if (exp_q.size() == 0) begin
                        fin = 1'b1;
                        cmd_valid = 1'b0;
                    end
                end
            end
            stall     = out_valid && !out_ready;
            prev_word = {out_last, out_data};
            bufd = bufd + h2 - pop;
            h2 = h1;
            h1 = int'(ram_re);
            if (noisy && !fin) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_addr  = 6'($urandom_range(0, 63));
                cmd_len   = 6'($urandom_range(0, 63));
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        check("cmd_timeout", int'(fin), 1);
        check("busy_end", int'(busy), 0);
        check("ready_end", int'(cmd_ready), 1);
        check("valid_end", int'(out_valid), 0);
        check("re_end", int'(ram_re), 0);
        check("issued_total", issued, len + 1);
        if (rdy_pct >= 100) begin
            check("first_latency", first_pop, 4);
            check("no_bubbles", last_pop - first_pop, len);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ram_re"}, int'(ram_re), 0);
        check({tag, "_ram_ore"}, int'(ram_ore), 0);
        check({tag, "_ram_ra"}, int'(ram_ra), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check_w({tag, "_out_word"}, {out_last, out_data}, 66'd0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_cmd_err"}, int'(cmd_err), 0);
    endtask

    initial begin
        int n_re;
        int guard;
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0;
        for (int i = 0; i < 61; i++) mem[i] = 65'(i);
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", int'(cmd_ready), 1);

        run_cmd(5, 0, 100, 1'b0);
        run_cmd(0, 60, 100, 1'b0);
        run_cmd(58, 4, 100, 1'b0);
        run_cmd(10, 20, 30, 1'b1);

        // Reset two cycles after the fifth read of a longer command
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 6'd20; cmd_len = 6'd9; out_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_re = 0; guard = 0;
        while (n_re < 5 && guard < 50) begin
            if (ram_re) n_re++;
            @(negedge clk);
            guard++;
        end
        check("mid_reads_seen", n_re, 5);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midreset");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_valid", int'(out_valid), 0);
            check("post_reset_ore", int'(ram_ore), 0);
            check("post_reset_ready", int'(cmd_ready), 1);
        end
        run_cmd(3, 1, 100, 1'b0);

`ifdef SA_RAM_RD_LEN_CHECK_EN
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 6'd61; cmd_len = 6'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("lenchk_err_pulse", int'(cmd_err), 1);
        check("lenchk_no_re", int'(ram_re), 0);
        check("lenchk_busy", int'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lenchk_err_clear", int'(cmd_err), 0);
            check("lenchk_no_re_after", int'(ram_re), 0);
            check("lenchk_idle", int'(busy), 0);
        end
`endif

        for (int i = 0; i < 61; i++)
            mem[i] = {1'($urandom_range(0, 1)), $urandom(), $urandom()};
        for (int r = 0; r < 8; r++)
            run_cmd($urandom_range(0, 60), $urandom_range(0, 60), $urandom_range(10, 100), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
